// File: rtl/servo_move_ctrl_if.sv
// Command channel between the motion host and servo_move_ctrl.
interface servo_move_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_pos;

    modport master (output cmd_valid, output cmd_pos, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_pos, output cmd_ready);
endinterface

// File: rtl/servo_move_ctrl.sv
// Move sequencer in front of the servo PWM block: steps l_ctrl/r_ctrl toward a
// commanded pulse position, waits a settle interval, then reports completion.
// Keeps a shadow of the servo position using the servo's own tick and step rule.
module servo_move_ctrl #(
    parameter int unsigned PULSE_0       = 5,
    parameter int unsigned PULSE_180     = 25,
    parameter int unsigned STEP_SIZE     = 2,
    parameter int unsigned SLOW_TICK_MAX = 1000,
    parameter int unsigned SETTLE_TICKS  = 3
) (
    input  logic             clk,
    input  logic             rst,
    servo_move_ctrl_if.slave cmd,
    input  logic             abort,
    input  logic             man_l,
    input  logic             man_r,
    output logic             l_ctrl,
    output logic             r_ctrl,
    output logic [4:0]       pos,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int unsigned PW = 5;
    localparam int unsigned AW = 6;
    localparam int unsigned TW = (SLOW_TICK_MAX > 1) ? $clog2(SLOW_TICK_MAX) : 1;
    localparam int unsigned SW = $clog2(SETTLE_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MANUAL,
        S_MOVE,
        S_SETTLE
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [PW-1:0]   goal;
    logic [SW-1:0]   settle_cnt;

    logic            tick;
    logic            handshake;
    logic            need_r;
    logic            need_l;
    logic            arrived;
    logic [AW-1:0]   pos_w;
    logic [AW-1:0]   goal_w;
    logic [AW-1:0]   step_w;
    logic [AW-1:0]   pos_up;
    logic [AW-1:0]   pos_dn;
    logic [AW-1:0]   cmd_w;
    logic [AW-1:0]   goal_in;

    assign cmd.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign handshake     = cmd.cmd_valid && (state == S_IDLE);
    assign tick          = (tick_cnt == TW'(SLOW_TICK_MAX - 1));

    // Saturating step arithmetic, goal clamping and arrival test, all at 6 bits.
    always_comb begin
        pos_w   = AW'(pos);
        goal_w  = AW'(goal);
        step_w  = AW'(STEP_SIZE);
        cmd_w   = AW'(cmd.cmd_pos);

        pos_up  = pos_w + step_w;
        if (pos_up > AW'(PULSE_180)) begin
            pos_up = AW'(PULSE_180);
        end

        pos_dn  = AW'(PULSE_0);
        if (pos_w >= AW'(PULSE_0) + step_w) begin
            pos_dn = pos_w - step_w;
        end

        goal_in = cmd_w;
        if (cmd_w < AW'(PULSE_0)) begin
            goal_in = AW'(PULSE_0);
        end else if (cmd_w > AW'(PULSE_180)) begin
            goal_in = AW'(PULSE_180);
        end

        need_r  = (goal_w >= pos_w + step_w);
        need_l  = (pos_w >= goal_w + step_w);
        arrived = !need_r && !need_l;
    end

    // Tick divider, shadow position, and the move/manual/settle sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            pos        <= PW'(PULSE_0);
            goal       <= PW'(PULSE_0);
            settle_cnt <= '0;
            l_ctrl     <= 1'b0;
            r_ctrl     <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            if (tick) begin
                if (r_ctrl) begin
                    pos <= PW'(pos_up);
                end else if (l_ctrl) begin
                    pos <= PW'(pos_dn);
                end
            end

            done    <= 1'b0;
            aborted <= 1'b0;

            case (state)
                S_IDLE: begin
                    l_ctrl <= 1'b0;
                    r_ctrl <= 1'b0;
                    if (handshake) begin
                        goal  <= PW'(goal_in);
                        state <= S_MOVE;
                    end else if (man_l ^ man_r) begin
                        state <= S_MANUAL;
                    end
                end

                S_MANUAL: begin
                    r_ctrl <= man_r & ~man_l;
                    l_ctrl <= man_l & ~man_r;
                    if (!(man_l ^ man_r)) begin
                        state <= S_IDLE;
                    end
                end

                S_MOVE: begin
                    if (abort) begin
                        l_ctrl  <= 1'b0;
                        r_ctrl  <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= S_IDLE;
                    end else if (arrived) begin
                        l_ctrl     <= 1'b0;
                        r_ctrl     <= 1'b0;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end else begin
                        r_ctrl <= need_r;
                        l_ctrl <= need_l;
                    end
                end

                S_SETTLE: begin
                    l_ctrl <= 1'b0;
                    r_ctrl <= 1'b0;
                    if (abort) begin
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= S_IDLE;
                    end else if (tick) begin
                        if (settle_cnt == SW'(SETTLE_TICKS - 1)) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    l_ctrl <= 1'b0;
                    r_ctrl <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_move_ctrl.sv
// Bench for servo_move_ctrl: table of commands, directed corner sequences,
// and random commands/aborts checked against an arithmetic position model.
module tb_servo_move_ctrl;

    localparam int P0     = 5;
    localparam int P180   = 25;
    localparam int STEP   = 2;
    localparam int TMAX   = 4;
    localparam int SETTLE = 3;

    logic       clk;
    logic       rst;
    logic       abort;
    logic       man_l;
    logic       man_r;
    logic       l_ctrl;
    logic       r_ctrl;
    logic [4:0] pos;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_tests = 0;
    int n_fail  = 0;

    servo_move_ctrl_if cmd_if ();

    servo_move_ctrl #(
        .PULSE_0      (P0),
        .PULSE_180    (P180),
        .STEP_SIZE    (STEP),
        .SLOW_TICK_MAX(TMAX),
        .SETTLE_TICKS (SETTLE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (cmd_if.slave),
        .abort  (abort),
        .man_l  (man_l),
        .man_r  (man_r),
        .l_ctrl (l_ctrl),
        .r_ctrl (r_ctrl),
        .pos    (pos),
        .busy   (busy),
        .done   (done),
        .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    typedef struct {
        logic [4:0] cmd_pos;
        int         exp_pos;
        int         exp_steps;
    } vec_t;

    vec_t tbl [12];

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_goal(input int p);
        if (p < P0) return P0;
        if (p > P180) return P180;
        return p;
    endfunction

    // Where a completed move must end: whole steps toward the goal, never past it.
    function automatic int model_final(input int start, input int p);
        int g;
        g = clamp_goal(p);
        if (g >= start) return start + ((g - start) / STEP) * STEP;
        return start - ((start - g) / STEP) * STEP;
    endfunction

    task automatic send_cmd(input logic [4:0] p);
        int guard;
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 200) begin
            cyc();
            guard++;
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos   = p;
        cyc();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output bit ab,
                             output int steps, output int gap, output bit both);
        int prev;
        int last;
        prev  = int'(pos);
        last  = 0;
        got   = 1'b0;
        ab    = 1'b0;
        steps = 0;
        gap   = -1;
        both  = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            cyc();
            if (l_ctrl && r_ctrl) both = 1'b1;
            if (int'(pos) != prev) begin
                steps++;
                last = i;
                prev = int'(pos);
            end
            if (done) begin
                got = 1'b1;
                ab  = aborted;
                gap = i - last;
                break;
            end
        end
    endtask

    task automatic wait_pos(input string name, input int target);
        int i;
        i = 0;
        while (int'(pos) != target && i < 200) begin
            cyc();
            i++;
        end
        chk(name, int'(pos), target);
    endtask

    initial begin
        bit got;
        bit ab;
        bit both;
        bit seen;
        bit early;
        int steps;
        int gap;
        int exp_pos;
        int fin;
        int start;
        int p;
        int d;
        int lo;
        int hi;
        bit do_abort;

        rst = 1'b1; abort = 1'b0; man_l = 1'b0; man_r = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_pos   = '0;

        tbl[0]  = '{5'd25, 25, 10};
        tbl[1]  = '{5'd12, 13, 6};
        tbl[2]  = '{5'd4,  5,  4};
        tbl[3]  = '{5'd12, 11, 3};
        tbl[4]  = '{5'd4,  5,  3};
        tbl[5]  = '{5'd31, 25, 10};
        tbl[6]  = '{5'd25, 25, 0};
        tbl[7]  = '{5'd0,  5,  10};
        tbl[8]  = '{5'd6,  5,  0};
        tbl[9]  = '{5'd20, 19, 7};
        tbl[10] = '{5'd18, 19, 0};
        tbl[11] = '{5'd5,  5,  7};

        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_pos",     int'(pos), P0);
        chk("rst_l_ctrl",  int'(l_ctrl), 0);
        chk("rst_r_ctrl",  int'(r_ctrl), 0);
        chk("rst_ready",   int'(cmd_if.cmd_ready), 1);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_done",    int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);

        // Table of back-to-back commands starting from PULSE_0.
        foreach (tbl[i]) begin
            send_cmd(tbl[i].cmd_pos);
            wait_done(300, got, ab, steps, gap, both);
            chk($sformatf("tbl%0d_done_seen", i), int'(got), 1);
            chk($sformatf("tbl%0d_aborted", i), int'(ab), 0);
            chk($sformatf("tbl%0d_pos", i), int'(pos), tbl[i].exp_pos);
            chk($sformatf("tbl%0d_steps", i), steps, tbl[i].exp_steps);
            chk($sformatf("tbl%0d_both_ctrl", i), int'(both), 0);
            chk($sformatf("tbl%0d_ready_at_done", i), int'(cmd_if.cmd_ready), 1);
            if (tbl[i].exp_steps > 0)
                chk($sformatf("tbl%0d_settle_gap", i), gap, SETTLE * TMAX);
            cyc();
            chk($sformatf("tbl%0d_done_width", i), int'(done), 0);
        end

        // Latency and abort two ticks into a 5->25 move.
        send_cmd(5'd25);
        chk("lat_busy", int'(busy), 1);
        chk("lat_r_early", int'(r_ctrl), 0);
        cyc();
        chk("lat_r_valid", int'(r_ctrl), 1);
        wait_pos("abort_reach9", 9);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_r_ctrl",  int'(r_ctrl), 0);
        chk("abort_done",    int'(done), 1);
        chk("abort_aborted", int'(aborted), 1);
        chk("abort_pos",     int'(pos), 9);
        chk("abort_busy",    int'(busy), 0);
        cyc();
        chk("abort_done_width", int'(done), 0);

        // Abort is ignored in IDLE.
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("idle_abort_done", int'(done), 0);
        chk("idle_abort_busy", int'(busy), 0);

        // Abort on the same edge as settle completion reports aborted.
        send_cmd(5'd13);
        wait_pos("settle_reach13", 13);
        early = 1'b0;
        repeat (SETTLE * TMAX - 1) begin
            cyc();
            if (done) early = 1'b1;
        end
        chk("settle_no_early_done", int'(early), 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("settle_abort_done",    int'(done), 1);
        chk("settle_abort_aborted", int'(aborted), 1);
        cyc();

        // Handshake and manual button together: command wins.
        man_r = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos   = 5'd13;
        cyc();
        man_r = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        chk("cmdwin_busy",  int'(busy), 1);
        chk("cmdwin_ready", int'(cmd_if.cmd_ready), 0);
        cyc();
        chk("cmdwin_r_ctrl", int'(r_ctrl), 0);
        wait_done(300, got, ab, steps, gap, both);
        chk("cmdwin_done",    int'(got), 1);
        chk("cmdwin_aborted", int'(ab), 0);
        chk("cmdwin_pos",     int'(pos), 13);
        cyc();

        // Manual right button alone, then both buttons to release.
        man_r = 1'b1;
        cyc();
        chk("man_busy",  int'(busy), 1);
        chk("man_ready", int'(cmd_if.cmd_ready), 0);
        cyc();
        chk("man_r_ctrl", int'(r_ctrl), 1);
        chk("man_l_ctrl", int'(l_ctrl), 0);
        repeat (2 * TMAX) cyc();
        chk("man_pos", int'(pos), 17);
        man_l = 1'b1;
        cyc();
        chk("man_both_r", int'(r_ctrl), 0);
        chk("man_both_l", int'(l_ctrl), 0);
        chk("man_both_idle", int'(busy), 0);
        chk("man_both_ready", int'(cmd_if.cmd_ready), 1);
        man_l = 1'b0;
        man_r = 1'b0;
        cyc();

        // Reset in the middle of a move.
        send_cmd(5'd5);
        cyc();
        chk("rstmid_moving", int'(l_ctrl), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstmid_l_ctrl", int'(l_ctrl), 0);
        chk("rstmid_r_ctrl", int'(r_ctrl), 0);
        chk("rstmid_busy",   int'(busy), 0);
        chk("rstmid_pos",    int'(pos), P0);
        chk("rstmid_ready",  int'(cmd_if.cmd_ready), 1);

        // Random commands with occasional aborts against the position model.
        exp_pos = P0;
        for (int it = 0; it < 30; it++) begin
            p        = int'($urandom_range(0, 31));
            do_abort = ($urandom_range(0, 3) == 0);
            d        = int'($urandom_range(0, 30));
            start    = exp_pos;
            fin      = model_final(start, p);
            send_cmd(5'(p));
            if (do_abort) begin
                seen = 1'b0;
                for (int k = 0; k < d; k++) begin
                    cyc();
                    if (done) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    chk($sformatf("rnd%0d_early_aborted", it), int'(aborted), 0);
                    chk($sformatf("rnd%0d_early_pos", it), int'(pos), fin);
                    exp_pos = fin;
                end else begin
                    abort = 1'b1;
                    cyc();
                    abort = 1'b0;
                    chk($sformatf("rnd%0d_abort_done", it), int'(done), 1);
                    chk($sformatf("rnd%0d_abort_flag", it), int'(aborted), 1);
                    lo = (start < fin) ? start : fin;
                    hi = (start < fin) ? fin : start;
                    chk($sformatf("rnd%0d_abort_pos_on_path", it),
                        int'(int'(pos) >= lo && int'(pos) <= hi && ((int'(pos) - start) % STEP) == 0), 1);
                    exp_pos = int'(pos);
                end
            end else begin
                wait_done(300, got, ab, steps, gap, both);
                chk($sformatf("rnd%0d_done", it), int'(got), 1);
                chk($sformatf("rnd%0d_aborted", it), int'(ab), 0);
                chk($sformatf("rnd%0d_pos", it), int'(pos), fin);
                chk($sformatf("rnd%0d_steps", it), steps, (fin > start ? fin - start : start - fin) / STEP);
                chk($sformatf("rnd%0d_both_ctrl", it), int'(both), 0);
                exp_pos = fin;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_move_ctrl.md
Name: servo_move_ctrl

Overview:
- Sequencer in front of the servo PWM block. It accepts a target pulse-width position over a valid/ready command interface.
- It drives the servo's l_ctrl/r_ctrl step inputs until the position reaches the target, waits a settle interval, then reports completion.
- It keeps a shadow copy of the servo position, using the same tick cadence and the same saturating step rule as the servo.
- It also passes through manual left/right buttons when no command is active.

Parameters:
- PULSE_0, 5: minimum position (pulse units).
- PULSE_180, 25: maximum position.
- STEP_SIZE, 2: position change per step tick.
- SLOW_TICK_MAX, 1000: clocks per step tick. Must be >= 2.
- SETTLE_TICKS, 3: step ticks to wait after arrival before done.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when a command can be accepted
- cmd_pos  in  5  target position (unsigned), clamped internally
- abort  in  1  cancel the active command
- man_l  in  1  manual left button
- man_r  in  1  manual right button
- l_ctrl  out  1  to servo l_ctrl (registered)
- r_ctrl  out  1  to servo r_ctrl (registered)
- pos  out  5  shadow servo position
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  qualifies done: 1 = command cancelled

Behaviour:
- One clock: clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, tick_cnt=0, pos=PULSE_0, goal=PULSE_0, settle_cnt=0. Outputs l_ctrl, r_ctrl, done, aborted, busy all 0; cmd_ready=1.
- Reset mid-move drops l_ctrl/r_ctrl on the following edge. The servo must be reset together with this block so tick phases align.
- Tick generation:
  - tick_cnt runs free from 0 to SLOW_TICK_MAX-1, then wraps to 0.
  - tick is asserted when tick_cnt==SLOW_TICK_MAX-1.
  - The tick is independent of state.
- Shadow position: on each tick, using the current registered l_ctrl/r_ctrl:
  - r_ctrl=1: pos <= min(pos+STEP_SIZE, PULSE_180).
  - Else l_ctrl=1: pos <= max(pos-STEP_SIZE, PULSE_0).
  - Arithmetic is done at 6 bits or wider so no wrap occurs.
- Command acceptance:
  - cmd_ready = (state==IDLE).
  - A handshake (cmd_valid & cmd_ready) sets goal <= clamp(cmd_pos, PULSE_0, PULSE_180) and moves to MOVE.
  - If a handshake and manual buttons occur in the same cycle, the command wins and the buttons are ignored.
- States:
  - IDLE:
    - l_ctrl=r_ctrl=0.
    - If there is no handshake and man_l XOR man_r: go to MANUAL.
  - MANUAL:
    - Each cycle, r_ctrl <= man_r & ~man_l and l_ctrl <= man_l & ~man_r.
    - When both buttons are 0 or both are 1: outputs go to 0 and state returns to IDLE.
    - cmd_ready=0 in this state.
    - pos tracks the manual steps through the normal tick rule.
  - MOVE:
    - Arrival means |goal-pos| < STEP_SIZE.
    - If arrived: l_ctrl<=0, r_ctrl<=0, settle_cnt<=0, go to SETTLE.
    - Otherwise: r_ctrl <= (goal >= pos+STEP_SIZE) and l_ctrl <= (pos >= goal+STEP_SIZE). Never both.
    - This makes odd distances stop one unit short, never overshoot.
  - SETTLE:
    - Outputs stay 0. settle_cnt increments on each tick.
    - When a tick occurs with settle_cnt==SETTLE_TICKS-1: pulse done=1 (aborted=0) and return to IDLE.
- Abort:
  - abort=1 in MOVE or SETTLE: next edge l_ctrl=r_ctrl=0, done=1, aborted=1, state IDLE.
  - goal is retained; pos keeps the value reached.
  - abort has priority over arrival and settle completion in the same cycle.
  - abort is ignored in IDLE and MANUAL.
- done/aborted:
  - Each is high for exactly one cycle per terminated command.
  - cmd_ready is high again in the cycle done is high, so back-to-back commands are allowed.
- Latency:
  - Handshake at edge N → MOVE at N+1 → r_ctrl/l_ctrl valid at N+2.
  - The pos update follows the first tick after that.

Test Plan (bench uses SLOW_TICK_MAX=4, SETTLE_TICKS=3):
- Reset → pos=5, l_ctrl=r_ctrl=0, cmd_ready=1, busy=0, done=0. Assert rst mid-MOVE → l_ctrl/r_ctrl=0 and state IDLE on the next edge.
- cmd_pos=25 from pos=5 → r_ctrl high for 10 ticks; pos steps 7,9,…,25; then r_ctrl=0, 3 ticks in SETTLE, done=1 with aborted=0 for one cycle, cmd_ready=1.
- cmd_pos=12 from pos=5 → stops at pos=11 (diff 1 < STEP) → done. Then cmd_pos=4 → clamped goal 5; l_ctrl steps 9,7,5; done.
- cmd_pos=31 → goal=25. Separately, cmd_pos equal to pos → MOVE for one cycle with no l_ctrl/r_ctrl pulse → SETTLE → done.
- abort two ticks into a 5→25 move → next edge r_ctrl=0, done=1, aborted=1, pos=9, IDLE. abort coinciding with settle completion → aborted=1.
- In IDLE, man_r=1 and cmd_valid=1 in the same cycle → command accepted, not MANUAL. Later man_r alone → MANUAL, r_ctrl=1, cmd_ready=0. Then man_l=man_r=1 → outputs 0, IDLE.
